// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI channel-voice message parser.
package midi_pkg;

  typedef enum logic [1:0] {
    WAIT_STATUS = 2'd0,
    WAIT_DATA1  = 2'd1,
    WAIT_DATA2  = 2'd2
  } parser_state_t;

  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
  localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
  localparam logic [3:0] MIDI_POLY_AT  = 4'hA;
  localparam logic [3:0] MIDI_CC       = 4'hB;
  localparam logic [3:0] MIDI_PROG     = 4'hC;
  localparam logic [3:0] MIDI_CHAN_AT  = 4'hD;
  localparam logic [3:0] MIDI_PITCH    = 4'hE;

  localparam logic [7:0] MIDI_REALTIME_MIN = 8'hF8;

  // Number of data bytes that follow a channel status byte.
  function automatic logic [1:0] midi_data_len(input logic [7:0] status);
    if (status[7:4] == MIDI_PROG || status[7:4] == MIDI_CHAN_AT)
      return 2'd1;
    else
      return 2'd2;
  endfunction

endpackage

// File: rtl/midi_byte_strobe.sv
// Turns the UART level-style valid into a single-cycle strobe per received byte.
module midi_byte_strobe (
  input  logic clk_100mhz,
  input  logic reset,
  input  logic byte_valid,
  output logic strobe
);

  logic prev_valid;

  // History resets high so a valid already asserted out of reset is not taken as a byte.
  always_ff @(posedge clk_100mhz) begin
    if (reset)
      prev_valid <= 1'b1;
    else
      prev_valid <= byte_valid;
  end

  assign strobe = byte_valid & ~prev_valid;

endmodule

// File: rtl/midi_msg_parser.sv
// Assembles MIDI channel-voice messages from received bytes and emits note events.
//   state       | meaning
//   WAIT_STATUS | idle; data bytes reuse running status as DATA1
//   WAIT_DATA1  | status seen, expecting first data byte
//   WAIT_DATA2  | first data byte stored, expecting second
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter logic       OMNI    = 1'b1,
  parameter logic [3:0] CHANNEL = 4'h0
) (
  input  logic       clk_100mhz,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       event_valid,
  output logic       event_note_on,
  output logic [3:0] event_channel,
  output logic [6:0] event_note,
  output logic [6:0] event_velocity,
  output logic [7:0] running_status
);

  parser_state_t state;
  logic [6:0]    d1;
  logic          strobe;
  logic          is_realtime;
  logic          is_system;
  logic          is_status;
  logic          one_byte_msg;
  logic          is_note_msg;
  logic          chan_ok;
  logic          note_on_now;

  midi_byte_strobe u_strobe (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .byte_valid (byte_valid),
    .strobe     (strobe)
  );

  assign is_realtime  = (byte_in >= MIDI_REALTIME_MIN);
  assign is_system    = (byte_in >= 8'hF0) && !is_realtime;
  assign is_status    = byte_in[7] && !is_system && !is_realtime;
  assign one_byte_msg = (midi_data_len(running_status) == 2'd1);
  assign is_note_msg  = (running_status[7:4] == MIDI_NOTE_ON) ||
                        (running_status[7:4] == MIDI_NOTE_OFF);
  assign chan_ok      = OMNI || (running_status[3:0] == CHANNEL);
  assign note_on_now  = (running_status[7:4] == MIDI_NOTE_ON) && (byte_in[6:0] != 7'd0);

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      state          <= WAIT_STATUS;
      d1             <= 7'd0;
      running_status <= 8'h00;
      event_valid    <= 1'b0;
      event_note_on  <= 1'b0;
      event_channel  <= 4'd0;
      event_note     <= 7'd0;
      event_velocity <= 7'd0;
    end else begin
      event_valid <= 1'b0;
      if (strobe && !is_realtime) begin
        if (is_system) begin
          running_status <= 8'h00;
          state          <= WAIT_STATUS;
        end else if (is_status) begin
          running_status <= byte_in;
          state          <= WAIT_DATA1;
        end else begin
          case (state)
            WAIT_STATUS: begin
              if (running_status != 8'h00 && !one_byte_msg) begin
                d1    <= byte_in[6:0];
                state <= WAIT_DATA2;
              end
            end
            WAIT_DATA1: begin
              d1    <= byte_in[6:0];
              state <= one_byte_msg ? WAIT_STATUS : WAIT_DATA2;
            end
            WAIT_DATA2: begin
              state <= WAIT_STATUS;
              if (is_note_msg && chan_ok) begin
                event_valid    <= 1'b1;
                event_note_on  <= note_on_now;
                event_channel  <= running_status[3:0];
                event_note     <= d1;
                event_velocity <= note_on_now ? byte_in[6:0] : 7'd0;
              end
            end
            default: state <= WAIT_STATUS;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_msg_parser.sv
// Directed bench: an OMNI parser and a channel-2-only parser share one byte stream.
module tb_midi_msg_parser;

  logic       clk_100mhz = 1'b0;
  logic       reset;
  logic [7:0] byte_in;
  logic       byte_valid;

  logic       a_ev, a_on, b_ev, b_on;
  logic [3:0] a_ch, b_ch;
  logic [6:0] a_note, a_vel, b_note, b_vel;
  logic [7:0] a_rs, b_rs;

  int checks = 0;
  int failures = 0;
  int cnt_a = 0;
  int cnt_b = 0;
  int snap_a, snap_b;

  always #5 clk_100mhz = ~clk_100mhz;

  midi_msg_parser #(.OMNI(1'b1), .CHANNEL(4'h0)) dut_a (
    .clk_100mhz (clk_100mhz), .reset (reset), .byte_in (byte_in), .byte_valid (byte_valid),
    .event_valid (a_ev), .event_note_on (a_on), .event_channel (a_ch),
    .event_note (a_note), .event_velocity (a_vel), .running_status (a_rs)
  );

  midi_msg_parser #(.OMNI(1'b0), .CHANNEL(4'h2)) dut_b (
    .clk_100mhz (clk_100mhz), .reset (reset), .byte_in (byte_in), .byte_valid (byte_valid),
    .event_valid (b_ev), .event_note_on (b_on), .event_channel (b_ch),
    .event_note (b_note), .event_velocity (b_vel), .running_status (b_rs)
  );

  // Pulse counters: every cycle with event_valid high counts once.
  always @(negedge clk_100mhz) begin
    if (a_ev) cnt_a++;
    if (b_ev) cnt_b++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drop valid for a cycle, present the byte, return #1 after the edge that samples its strobe.
  task automatic send(input logic [7:0] b);
    @(negedge clk_100mhz);
    byte_valid = 1'b0;
    @(negedge clk_100mhz);
    byte_in    = b;
    byte_valid = 1'b1;
    @(posedge clk_100mhz);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_100mhz);
    reset = 1'b1;
    repeat (2) @(negedge clk_100mhz);
    reset = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk_100mhz);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    byte_in    = 8'h93;
    byte_valid = 1'b1;
    repeat (3) @(negedge clk_100mhz);
    reset = 1'b0;
    repeat (3) @(negedge clk_100mhz);
    #1;
    check("reset_ev", a_ev, 1'b0);
    check("reset_rs", a_rs, 8'h00);
    check("reset_cnt", cnt_a, 0);
    check("reset_fields", {a_on, a_ch, a_note, a_vel}, 19'd0);

    // Basic note-on on channel 3
    snap_a = cnt_a; snap_b = cnt_b;
    send(8'h93);
    check("t1_rs", a_rs, 8'h93);
    send(8'h3C);
    check("t1_mid_ev", a_ev, 1'b0);
    send(8'h64);
    check("t1_ev", a_ev, 1'b1);
    check("t1_on", a_on, 1'b1);
    check("t1_ch", a_ch, 4'd3);
    check("t1_note", a_note, 7'h3C);
    check("t1_vel", a_vel, 7'h64);
    check("t1_b_filtered", b_ev, 1'b0);
    @(posedge clk_100mhz); #1;
    check("t1_pulse_width", a_ev, 1'b0);
    check("t1_hold_note", a_note, 7'h3C);
    settle();
    check("t1_cnt_a", cnt_a - snap_a, 1);
    check("t1_cnt_b", cnt_b - snap_b, 0);

    // Running status: note-on, then velocity-0 note-off
    send(8'h90); send(8'h40); send(8'h7F);
    check("t2_on", {a_ev, a_on, a_ch, a_note, a_vel}, {1'b1, 1'b1, 4'd0, 7'h40, 7'h7F});
    send(8'h40); send(8'h00);
    check("t2_off", {a_ev, a_on, a_ch, a_note, a_vel}, {1'b1, 1'b0, 4'd0, 7'h40, 7'h00});
    check("t2_rs", a_rs, 8'h90);

    // Real-time bytes interleaved mid-message
    settle();
    snap_a = cnt_a;
    send(8'h90); send(8'hF8);
    check("t3_rs_rt", a_rs, 8'h90);
    send(8'h45); send(8'hFE);
    check("t3_mid_ev", a_ev, 1'b0);
    send(8'h50);
    check("t3_ev", {a_ev, a_on, a_note, a_vel}, {1'b1, 1'b1, 7'h45, 7'h50});
    settle();
    check("t3_cnt", cnt_a - snap_a, 1);

    // New status mid-message discards the partial note-on
    snap_a = cnt_a;
    send(8'h90); send(8'h30); send(8'h80); send(8'h30);
    check("t4_mid_ev", a_ev, 1'b0);
    send(8'h00);
    check("t4_off", {a_ev, a_on, a_ch, a_note, a_vel}, {1'b1, 1'b0, 4'd0, 7'h30, 7'h00});
    settle();
    check("t4_cnt", cnt_a - snap_a, 1);

    // Note-off with nonzero velocity reports velocity 0
    send(8'h85); send(8'h22); send(8'h33);
    check("t5_off", {a_ev, a_on, a_ch, a_note, a_vel}, {1'b1, 1'b0, 4'd5, 7'h22, 7'h00});

    // Control change and SysEx: silent; SysEx clears running status
    settle();
    snap_a = cnt_a;
    send(8'hB0); send(8'h07); send(8'h64);
    send(8'h90); send(8'hF0);
    check("t6_rs_sysex", a_rs, 8'h00);
    send(8'h40); send(8'h40);
    settle();
    check("t6_cnt", cnt_a - snap_a, 0);

    // Reset mid-message and stray data after reset
    send(8'h90); send(8'h40);
    do_reset();
    #1;
    check("t7_rs_reset", a_rs, 8'h00);
    snap_a = cnt_a;
    send(8'h7F); send(8'h12);
    settle();
    check("t7_cnt", cnt_a - snap_a, 0);
    check("t7_rs", a_rs, 8'h00);

    // Channel filter on the OMNI=0, CHANNEL=2 instance
    snap_b = cnt_b;
    send(8'h91); send(8'h3C); send(8'h40);
    check("t8_a_sees_ch1", a_ev, 1'b1);
    check("t8_b_blocked", b_ev, 1'b0);
    send(8'hC2); send(8'h05);
    check("t8_prog_ev", b_ev, 1'b0);
    send(8'h06);
    check("t8_prog_rs", b_rs, 8'hC2);
    send(8'h92); send(8'h3C); send(8'h40);
    check("t8_b_ev", {b_ev, b_on, b_ch, b_note, b_vel}, {1'b1, 1'b1, 4'd2, 7'h3C, 7'h40});
    settle();
    check("t8_cnt_b", cnt_b - snap_b, 1);
    // Running status on the filtered channel still works
    send(8'h3E); send(8'h00);
    check("t8_b_rs_off", {b_ev, b_on, b_ch, b_note, b_vel}, {1'b1, 1'b0, 4'd2, 7'h3E, 7'h00});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
